serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor_pkg.sv | 17 +
 rtl/serial_subtractor_fs_bit_cell.sv | 13 +
 rtl/serial_subtractor.sv | 130 +++++++++++++
 tb/tb_serial_subtractor.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Counter must hold 0..width without wrapping.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_subtractor_fs_bit_cell.sv
// One-bit full subtractor: d = ai - bi - bin, bo = borrow out.
module fs_bit_cell (
  input  logic ai,
  input  logic bi,
  input  logic bin,
  output logic d,
  output logic bo
);

  assign d  = ai ^ bi ^ bin;
  assign bo = (~ai & bi) | (~(ai ^ bi) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a-b, LSB first, one bit per clock; result published in DONE.
// Optional signed-overflow output enabled by macro SERIAL_SUBTRACTOR_OVF_EN.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             d_bit;
  logic             bo_bit;
  logic             last_bit;

  fs_bit_cell u_cell (
    .ai (a_sh[0]),
    .bi (b_sh[0]),
    .bin(br),
    .d  (d_bit),
    .bo (bo_bit)
  );

  assign last_bit = (state == RUN) && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN:     busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      cnt    <= '0;
      br     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            res_sh <= '0;
            cnt    <= '0;
            br     <= 1'b0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= {d_bit, res_sh[WIDTH-1:1]};
          cnt    <= cnt + 1'b1;
          br     <= bo_bit;
        end
        default: ;
      endcase
    end
  end

  // Result registers load on the final RUN edge, so they first show the new value in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff <= '0;
      bout <= 1'b0;
    end else if (last_bit) begin
      diff <= {d_bit, res_sh[WIDTH-1:1]};
      bout <= bo_bit;
    end
  end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  // On the last bit a_sh[0]/b_sh[0] are the original operand sign bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (last_bit) begin
      ovf <= (a_sh[0] != b_sh[0]) && (d_bit != a_sh[0]);
    end
  end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and exhaustive-WIDTH=4 checks for serial_subtractor.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a, b;
  logic       busy, done, bout;
  logic [7:0] diff;

  logic       s_start;
  logic [3:0] s_a, s_b;
  logic       s_busy, s_done, s_bout;
  logic [3:0] s_diff;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic ovf, s_ovf;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .bout(bout)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    , .ovf(ovf)
`endif
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .a(s_a), .b(s_b),
    .busy(s_busy), .done(s_done), .diff(s_diff), .bout(s_bout)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    , .ovf(s_ovf)
`endif
  );

  // Launch one op; lat counts rising edges from the accepting edge to the first done sample.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                        output int lat, output logic busy_run);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start = 1'b0;
    busy_run = busy;
    while (!done && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    $display("op a=%h b=%h -> diff=%h bout=%b lat=%0d", av, bv, diff, bout, lat);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = 8'h0; b = 8'h0;
    s_start = 1'b0; s_a = 4'h0; s_b = 4'h0;
    #2;
    total++;
    if ({busy, done, diff, bout} !== 11'b0) begin
      bad++; $display("FAIL reset_outputs got=%b exp=0", {busy, done, diff, bout});
    end
    repeat (3) @(negedge clk);
    total++;
    if ({s_busy, s_done, s_diff, s_bout} !== 7'b0) begin
      bad++; $display("FAIL reset_outputs_w4 got=%b exp=0", {s_busy, s_done, s_diff, s_bout});
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_basic();
    int lat; logic br;
    run_op(8'h0F, 8'h05, lat, br);
    total++; if (lat !== 9) begin bad++; $display("FAIL basic_latency got=%0d exp=9", lat); end
    total++; if (br !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b exp=1", br); end
    total++; if (diff !== 8'h0A) begin bad++; $display("FAIL basic_diff got=%h exp=0a", diff); end
    total++; if (bout !== 1'b0) begin bad++; $display("FAIL basic_bout got=%b exp=0", bout); end
    @(negedge clk);
    total++;
    if ({busy, done} !== 2'b00) begin bad++; $display("FAIL basic_after got=%b exp=00", {busy, done}); end
    total++; if (diff !== 8'h0A) begin bad++; $display("FAIL basic_hold got=%h exp=0a", diff); end
  endtask

  task automatic test_borrow();
    int lat; logic br;
    run_op(8'h00, 8'hFF, lat, br);
    total++; if (diff !== 8'h01) begin bad++; $display("FAIL borrow_diff got=%h exp=01", diff); end
    total++; if (bout !== 1'b1) begin bad++; $display("FAIL borrow_bout got=%b exp=1", bout); end
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL borrow_ovf got=%b exp=0", ovf); end
`endif
    run_op(8'h5A, 8'hC3, lat, br);
    total++; if (diff !== 8'h97) begin bad++; $display("FAIL mixed_diff got=%h exp=97", diff); end
    total++; if (bout !== 1'b1) begin bad++; $display("FAIL mixed_bout got=%b exp=1", bout); end
  endtask

  task automatic test_ovf();
    int lat; logic br;
    run_op(8'h80, 8'h01, lat, br);
    total++; if (diff !== 8'h7F) begin bad++; $display("FAIL ovf_diff got=%h exp=7f", diff); end
    total++; if (bout !== 1'b0) begin bad++; $display("FAIL ovf_bout got=%b exp=0", bout); end
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", ovf); end
`endif
  endtask

  task automatic test_ignore_start();
    int dones = 0;
    @(negedge clk);
    a = 8'h3C; b = 8'h11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    a = 8'h01; b = 8'h02; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL ignore_busy got=%b exp=1", busy); end
    repeat (20) begin
      if (done) dones++;
      @(negedge clk);
    end
    $display("op a=3c b=11 (start pulse in RUN) -> diff=%h bout=%b dones=%0d", diff, bout, dones);
    total++; if (dones !== 1) begin bad++; $display("FAIL ignore_dones got=%0d exp=1", dones); end
    total++; if (diff !== 8'h2B) begin bad++; $display("FAIL ignore_diff got=%h exp=2b", diff); end
    total++; if (bout !== 1'b0) begin bad++; $display("FAIL ignore_bout got=%b exp=0", bout); end
  endtask

  task automatic test_reset_mid_run();
    int lat; int dones = 0; logic br;
    @(negedge clk);
    a = 8'hAA; b = 8'h55; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, diff, bout} !== 11'b0) begin
      bad++; $display("FAIL midrst_outputs got=%b exp=0", {busy, done, diff, bout});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) begin
      if (done) dones++;
      @(negedge clk);
    end
    total++; if (dones !== 0) begin bad++; $display("FAIL midrst_nodone got=%0d exp=0", dones); end
    run_op(8'h33, 8'h33, lat, br);
    total++; if (lat !== 9) begin bad++; $display("FAIL postrst_latency got=%0d exp=9", lat); end
    total++; if (diff !== 8'h00) begin bad++; $display("FAIL postrst_diff got=%h exp=00", diff); end
    total++; if (bout !== 1'b0) begin bad++; $display("FAIL postrst_bout got=%b exp=0", bout); end
  endtask

  task automatic test_sweep4();
    int idx = 0;
    int cyc = 0;
    int last = -1;
    logic [3:0] ea, eb, ed;
    logic       eo;
    @(negedge clk);
    s_a = 4'h0; s_b = 4'h0; s_start = 1'b1;
    while (idx < 256 && cyc < 256 * 6 + 50) begin
      @(negedge clk);
      cyc++;
      if (s_done) begin
        ea = 4'(idx >> 4);
        eb = 4'(idx);
        ed = ea - eb;
        eo = (ea < eb);
        $display("w4 a=%h b=%h -> diff=%h bout=%b", ea, eb, s_diff, s_bout);
        total++;
        if (s_diff !== ed) begin bad++; $display("FAIL sweep_diff a=%h b=%h got=%h exp=%h", ea, eb, s_diff, ed); end
        total++;
        if (s_bout !== eo) begin bad++; $display("FAIL sweep_bout a=%h b=%h got=%b exp=%b", ea, eb, s_bout, eo); end
        if (last >= 0) begin
          total++;
          if (cyc - last !== 6) begin bad++; $display("FAIL sweep_spacing got=%0d exp=6", cyc - last); end
        end
        last = cyc;
        idx++;
        s_a = 4'(idx >> 4);
        s_b = 4'(idx);
      end
    end
    s_start = 1'b0;
    total++;
    if (idx !== 256) begin bad++; $display("FAIL sweep_count got=%0d exp=256", idx); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_ovf();
    test_ignore_start();
    test_reset_mid_run();
    test_sweep4();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
